gb_out_packer: RTL and testbench

- Sits directly downstream of the Gaussian-blur core and consumes its 8-bit output pixel stream (arg_0_TDATA/TVALID/TREADY).
- Packs 4 pixels into 32-bit AXI-stream words, padding the last word of each row with TKEEP.
- Marks row end with TLAST and frame start with TUSER, tracks row/column position, and reports frame completion.
- Feeds the DMA/memory writer, which takes 32-bit words.

---
 rtl/gb_pkg.sv | 32 +++
 rtl/gb_axis_reg.sv | 27 ++
 rtl/gb_out_packer.sv | 129 ++++++++++++
 tb/tb_gb_out_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// Shared definitions for the Gaussian-blur output stream path.
package gb_pkg;

  localparam int unsigned GB_PIX_W    = 8;
  localparam int unsigned GB_WORD_W   = 32;
  localparam int unsigned GB_LANES    = 4;

  localparam int          GB_COLS_DEF = 480;
  localparam int          GB_ROWS_DEF = 640;

  localparam int unsigned GB_COL_W    = 9;
  localparam int unsigned GB_ROW_W    = 10;

  // One outgoing AXI-stream beat.
  typedef struct packed {
    logic [GB_WORD_W-1:0] data;
    logic [GB_LANES-1:0]  keep;
    logic                 last;
    logic                 user;
  } gb_word_t;

  // Byte-valid mask covering lanes 0..lane inclusive.
  function automatic logic [GB_LANES-1:0] gb_keep_mask(input logic [1:0] lane);
    logic [GB_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < GB_LANES; i++) begin
      m[i] = (i <= 32'(lane));
    end
    return m;
  endfunction

endpackage

// File: rtl/gb_axis_reg.sv
// Single-entry AXI-stream output register; contents hold while stalled.
module gb_axis_reg
  import gb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_load,
  input  gb_word_t i_word,
  input  logic     i_ready,
  output logic     o_valid,
  output gb_word_t o_word
);

  // Load a new beat, otherwise drop valid once the current beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_word  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_word  <= i_word;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gb_out_packer.sv
// Packs the blur core's 8-bit pixel stream into 32-bit AXI-stream words
// with row (TLAST) and frame (TUSER) framing and a frame-done pulse.
module gb_out_packer
  import gb_pkg::*;
#(
  parameter int COLS = GB_COLS_DEF,
  parameter int ROWS = GB_ROWS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic [GB_PIX_W-1:0]   s_TDATA,
  input  logic                  s_TVALID,
  output logic                  s_TREADY,
  output logic [GB_WORD_W-1:0]  m_TDATA,
  output logic [GB_LANES-1:0]   m_TKEEP,
  output logic                  m_TVALID,
  input  logic                  m_TREADY,
  output logic                  m_TLAST,
  output logic                  m_TUSER,
  output logic                  frame_done,
  output logic [GB_COL_W-1:0]   col_idx,
  output logic [GB_ROW_W-1:0]   row_idx
);

  localparam logic [GB_COL_W-1:0] LAST_COL = GB_COL_W'(COLS - 1);
  localparam logic [GB_ROW_W-1:0] LAST_ROW = GB_ROW_W'(ROWS - 1);

  logic [1:0]           r_lane;
  logic [GB_WORD_W-1:0] r_pack;
  logic [GB_COL_W-1:0]  r_col;
  logic [GB_ROW_W-1:0]  r_row;
  logic                 r_eof_tag;
  logic                 r_frame_done;

  logic     w_closes;
  logic     w_s_fire;
  logic     w_m_fire;
  logic     w_load;
  logic     w_m_valid;
  gb_word_t w_new_word;
  gb_word_t w_out_word;

  assign w_closes = (r_lane == 2'd3) || (r_col == LAST_COL);

  // A closing byte needs the output slot; partial bytes go straight to the pack register.
  assign s_TREADY = step && !rst && (!w_closes || !w_m_valid || m_TREADY);
  assign w_s_fire = s_TVALID && s_TREADY;
  assign w_m_fire = w_m_valid && m_TREADY;
  assign w_load   = w_s_fire && w_closes;

  // Assemble the word a closing byte would produce: held lanes, the new byte, zero above.
  always_comb begin
    w_new_word = '0;
    for (int unsigned i = 0; i < GB_LANES; i++) begin
      if (i < 32'(r_lane)) begin
        w_new_word.data[8*i +: 8] = r_pack[8*i +: 8];
      end else if (i == 32'(r_lane)) begin
        w_new_word.data[8*i +: 8] = s_TDATA;
      end
    end
    w_new_word.keep = gb_keep_mask(r_lane);
    w_new_word.last = (r_col == LAST_COL);
    w_new_word.user = (r_row == '0) && (r_col < GB_COL_W'(4));
  end

  // Accumulate non-closing bytes; a closing byte restarts at lane 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (w_s_fire) begin
      if (w_closes) begin
        r_lane <= '0;
      end else begin
        r_pack[{r_lane, 3'b000} +: 8] <= s_TDATA;
        r_lane                        <= r_lane + 2'd1;
      end
    end
  end

  // Column/row position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_s_fire) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + GB_ROW_W'(1);
      end else begin
        r_col <= r_col + GB_COL_W'(1);
      end
    end
  end

  // End-of-frame tag travels with the held word; pulse once it is taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eof_tag    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_eof_tag <= w_new_word.last && (r_row == LAST_ROW);
      end
      r_frame_done <= w_m_fire && r_eof_tag;
    end
  end

  gb_axis_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_word  (w_new_word),
    .i_ready (m_TREADY),
    .o_valid (w_m_valid),
    .o_word  (w_out_word)
  );

  assign m_TVALID   = w_m_valid;
  assign m_TDATA    = w_out_word.data;
  assign m_TKEEP    = w_out_word.keep;
  assign m_TLAST    = w_out_word.last;
  assign m_TUSER    = w_out_word.user;
  assign frame_done = r_frame_done;
  assign col_idx    = r_col;
  assign row_idx    = r_row;

endmodule

// File: tb/tb_gb_out_packer.sv
// Scoreboard bench for gb_out_packer: three instances (6x2, 1x3, 480x4),
// exercised one at a time against a shared queue of expected words.
module tb_gb_out_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [3];
  logic        step    [3];
  logic [7:0]  s_data  [3];
  logic        s_valid [3];
  logic        s_ready [3];
  logic [31:0] m_data  [3];
  logic [3:0]  m_keep  [3];
  logic        m_valid [3];
  logic        m_ready [3];
  logic        m_last  [3];
  logic        m_user  [3];
  logic        fdone   [3];
  logic [8:0]  col     [3];
  logic [9:0]  row     [3];

  gb_out_packer #(.COLS(6), .ROWS(2)) dut_a (
    .clk(clk), .rst(rst[0]), .step(step[0]),
    .s_TDATA(s_data[0]), .s_TVALID(s_valid[0]), .s_TREADY(s_ready[0]),
    .m_TDATA(m_data[0]), .m_TKEEP(m_keep[0]), .m_TVALID(m_valid[0]), .m_TREADY(m_ready[0]),
    .m_TLAST(m_last[0]), .m_TUSER(m_user[0]), .frame_done(fdone[0]),
    .col_idx(col[0]), .row_idx(row[0]));

  gb_out_packer #(.COLS(1), .ROWS(3)) dut_b (
    .clk(clk), .rst(rst[1]), .step(step[1]),
    .s_TDATA(s_data[1]), .s_TVALID(s_valid[1]), .s_TREADY(s_ready[1]),
    .m_TDATA(m_data[1]), .m_TKEEP(m_keep[1]), .m_TVALID(m_valid[1]), .m_TREADY(m_ready[1]),
    .m_TLAST(m_last[1]), .m_TUSER(m_user[1]), .frame_done(fdone[1]),
    .col_idx(col[1]), .row_idx(row[1]));

  gb_out_packer #(.COLS(480), .ROWS(4)) dut_c (
    .clk(clk), .rst(rst[2]), .step(step[2]),
    .s_TDATA(s_data[2]), .s_TVALID(s_valid[2]), .s_TREADY(s_ready[2]),
    .m_TDATA(m_data[2]), .m_TKEEP(m_keep[2]), .m_TVALID(m_valid[2]), .m_TREADY(m_ready[2]),
    .m_TLAST(m_last[2]), .m_TUSER(m_user[2]), .frame_done(fdone[2]),
    .col_idx(col[2]), .row_idx(row[2]));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
    logic        eof;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic fd_exp [3];
  int   fd_cnt [3];
  logic c_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k,
                      input logic l, input logic u, input logic f);
    exp_t x;
    x.data = d; x.keep = k; x.last = l; x.user = u; x.eof = f;
    expq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the DUT accepts it (bounded).
  task automatic send(input int g, input logic [7:0] b);
    int t;
    s_data[g]  = b;
    s_valid[g] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_ready[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready[g]) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: inst %0d byte %h never accepted", g, b);
    end
    @(posedge clk);
    #1;
    s_valid[g] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    if (expq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still expected", expq.size());
      expq.delete();
    end
    repeat (3) tick();
  endtask

  task automatic frame_a_exp();
    push(32'h04030201, 4'hF, 1'b0, 1'b1, 1'b0);
    push(32'h00000605, 4'h3, 1'b1, 1'b0, 1'b0);
    push(32'h0A090807, 4'hF, 1'b0, 1'b0, 1'b0);
    push(32'h00000C0B, 4'h3, 1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: pop and compare on every accepted word; check frame_done timing.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (fd_exp[g] || fdone[g]) check("frame_done", 32'(fdone[g]), 32'(fd_exp[g]));
      if (fdone[g]) fd_cnt[g]++;
      fd_exp[g] = 1'b0;
      if (m_valid[g] && m_ready[g]) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: inst %0d got %h expected none", g, m_data[g]);
        end else begin
          e = expq.pop_front();
          check("word_data", m_data[g], e.data);
          check("word_keep", 32'(m_keep[g]), 32'(e.keep));
          check("word_last", 32'(m_last[g]), 32'(e.last));
          check("word_user", 32'(m_user[g]), 32'(e.user));
          fd_exp[g] = e.eof;
        end
      end
    end
  end

  // Random downstream backpressure for the large-frame instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (c_run) m_ready[2] = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; step[g] = 1'b1; s_valid[g] = 1'b0; s_data[g] = '0;
      m_ready[g] = 1'b1; fd_exp[g] = 1'b0; fd_cnt[g] = 0;
    end
    repeat (2) tick();
    @(negedge clk);
    check("rst_s_tready", 32'(s_ready[0]), 0);
    check("rst_m_tvalid", 32'(m_valid[0]), 0);
    check("rst_m_tdata", m_data[0], 0);
    check("rst_m_tkeep", 32'(m_keep[0]), 0);
    check("rst_col_row", {13'd0, row[0], col[0]}, 0);
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    tick();

    // Scenario 1: free-running stream.
    frame_a_exp();
    for (int b = 1; b <= 12; b++) send(0, 8'(b));
    drain();

    // Scenario 2: downstream stall after the first word.
    frame_a_exp();
    m_ready[0] = 1'b0;
    for (int b = 1; b <= 5; b++) send(0, 8'(b));
    s_data[0] = 8'h06;
    s_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_s_tready", 32'(s_ready[0]), 0);
      check("bp_hold_data", m_data[0], 32'h04030201);
      check("bp_hold_valid", 32'(m_valid[0]), 1);
      check("bp_col", 32'(col[0]), 5);
    end
    @(posedge clk);
    #1;
    m_ready[0] = 1'b1;
    for (int b = 6; b <= 12; b++) send(0, 8'(b));
    drain();

    // Scenario 3: step held low mid-word.
    frame_a_exp();
    send(0, 8'h01);
    send(0, 8'h02);
    step[0] = 1'b0;
    s_data[0] = 8'h03;
    s_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("step_s_tready", 32'(s_ready[0]), 0);
      check("step_col", 32'(col[0]), 2);
    end
    @(posedge clk);
    #1;
    step[0] = 1'b1;
    for (int b = 3; b <= 12; b++) send(0, 8'(b));
    drain();

    // Scenario 4: reset in the middle of row 1.
    push(32'h04030201, 4'hF, 1'b0, 1'b1, 1'b0);
    push(32'h00000605, 4'h3, 1'b1, 1'b0, 1'b0);
    for (int b = 1; b <= 7; b++) send(0, 8'(b));
    rst[0] = 1'b1;
    @(negedge clk);
    check("mrst_s_tready", 32'(s_ready[0]), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mrst_m_tvalid", 32'(m_valid[0]), 0);
    check("mrst_m_tdata", m_data[0], 0);
    check("mrst_flags", {28'd0, m_keep[0]} | {30'd0, m_last[0], m_user[0]}, 0);
    check("mrst_col_row", {13'd0, row[0], col[0]}, 0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    push(32'hA3A2A1A0, 4'hF, 1'b0, 1'b1, 1'b0);
    push(32'h0000A5A4, 4'h3, 1'b1, 1'b0, 1'b0);
    push(32'hB3B2B1B0, 4'hF, 1'b0, 1'b0, 1'b0);
    push(32'h0000B5B4, 4'h3, 1'b1, 1'b0, 1'b1);
    for (int b = 0; b < 6; b++) send(0, 8'(8'hA0 + b));
    for (int b = 0; b < 6; b++) send(0, 8'(8'hB0 + b));
    drain();
    check("frames_a", 32'(fd_cnt[0]), 4);

    // Scenario 5: one pixel per row.
    push(32'h00000011, 4'h1, 1'b1, 1'b1, 1'b0);
    push(32'h00000022, 4'h1, 1'b1, 1'b0, 1'b0);
    push(32'h00000033, 4'h1, 1'b1, 1'b0, 1'b1);
    send(1, 8'h11);
    send(1, 8'h22);
    send(1, 8'h33);
    drain();
    check("frames_b", 32'(fd_cnt[1]), 1);

    // Scenario 6: two 480x4 frames, random gaps and backpressure; pixel n = n mod 256.
    for (int j = 0; j < 960; j++) begin
      logic [7:0] p;
      p = 8'(4 * j);
      push({p + 8'd3, p + 8'd2, p + 8'd1, p}, 4'hF,
           (j % 120) == 119, (j % 480) == 0, (j % 480) == 479);
    end
    c_run = 1'b1;
    for (int n = 0; n < 3840; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(2, 8'(n));
    end
    c_run = 1'b0;
    #1;
    m_ready[2] = 1'b1;
    drain();
    check("frames_c", 32'(fd_cnt[2]), 2);
    check("c_col_row_end", {13'd0, row[2], col[2]}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
